// File: rtl/dac_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_spi_pkg : shared constants, FSM encoding and frame builder       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam int DATA_BITS  = 16;
  localparam int CMD_BITS   = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_X = 3'd1,
    S_GAP_X   = 3'd2,
    S_SHIFT_Y = 3'd3,
    S_GAP_Y   = 3'd4,
    S_LDAC    = 3'd5
  } state_t;

  // Offset binary is two's complement with the sign bit flipped.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [CMD_BITS-1:0]  cmd,
    input logic [DATA_BITS-1:0] sample,
    input logic                 offset_binary
  );
    return {cmd, sample[DATA_BITS-1] ^ offset_binary, sample[DATA_BITS-2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_frame_tx : one 24-bit SPI frame, MSB first, SCLK idles high      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_frame_tx
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_frame,
  output logic                  o_sclk,
  output logic                  o_sdo,
  output logic                  o_sync_n,
  output logic                  o_done
);

  localparam int                 c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [4:0]         c_bit_last = 5'(FRAME_BITS - 1);

  logic                  r_active;
  logic                  r_low;
  logic [c_div_w-1:0]    r_div;
  logic [4:0]            r_bit;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_sclk;
  logic                  r_sdo;
  logic                  r_sync_n;
  logic                  w_tick;

  assign w_tick = r_active && (r_div == c_div_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_low    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_sclk   <= 1'b1;
      r_sdo    <= 1'b0;
      r_sync_n <= 1'b1;
    end else if (i_start) begin
      // First bit is presented on the same edge that drops sync_n.
      r_active <= 1'b1;
      r_low    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= {i_frame[FRAME_BITS-2:0], 1'b0};
      r_sclk   <= 1'b1;
      r_sdo    <= i_frame[FRAME_BITS-1];
      r_sync_n <= 1'b0;
    end else if (r_active) begin
      if (w_tick) begin
        r_div <= '0;
        if (!r_low) begin
          r_low  <= 1'b1;
          r_sclk <= 1'b0;
        end else begin
          r_low  <= 1'b0;
          r_sclk <= 1'b1;
          if (r_bit == c_bit_last) begin
            r_active <= 1'b0;
            r_sync_n <= 1'b1;
            r_sdo    <= 1'b0;
          end else begin
            r_bit   <= r_bit + 5'd1;
            r_sdo   <= r_shift[FRAME_BITS-1];
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + c_div_w'(1);
      end
    end
  end

  assign o_done   = w_tick && r_low && (r_bit == c_bit_last);
  assign o_sclk   = r_sclk;
  assign o_sdo    = r_sdo;
  assign o_sync_n = r_sync_n;

endmodule
`default_nettype wire

// File: rtl/dac_spi_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_spi_writer : dual-channel SPI DAC writer with pending buffer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dac_spi_writer
  import dac_spi_pkg::*;
#(
  parameter int                CLK_DIV        = 2,
  parameter int                CS_HIGH_CYCLES = 4,
  parameter int                LDAC_CYCLES    = 2,
  parameter logic [CMD_BITS-1:0] CMD_X        = 8'h18,
  parameter logic [CMD_BITS-1:0] CMD_Y        = 8'h19,
  parameter bit                OFFSET_BINARY  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_x_in,
  input  logic [DATA_BITS-1:0] i_y_in,
  input  logic                 i_in_valid,
  output logic                 o_sclk,
  output logic                 o_sync_n,
  output logic                 o_sdo,
  output logic                 o_ldac_n,
  output logic                 o_busy,
  output logic [15:0]          o_overrun_count
);

  localparam logic [15:0] c_gap_last  = 16'(CS_HIGH_CYCLES - 1);
  localparam logic [15:0] c_ldac_last = 16'(LDAC_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_cnt;
  logic                  r_ldac_n;
  logic                  r_busy;
  logic                  r_pend_full;
  logic [DATA_BITS-1:0]  r_pend_x;
  logic [DATA_BITS-1:0]  r_pend_y;
  logic [DATA_BITS-1:0]  r_act_y;
  logic [15:0]           r_ovr;
  logic                  w_start;
  logic                  w_load;
  logic                  w_done;
  logic [FRAME_BITS-1:0] w_frame;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_frame     = build_frame(CMD_Y, r_act_y, OFFSET_BINARY);
    case (r_state)
      S_IDLE: begin
        // X is launched straight from the pending slot; Y is kept frozen in r_act_y.
        if (r_pend_full) begin
          w_state_nxt = S_SHIFT_X;
          w_start     = 1'b1;
          w_load      = 1'b1;
          w_frame     = build_frame(CMD_X, r_pend_x, OFFSET_BINARY);
        end
      end
      S_SHIFT_X: if (w_done) w_state_nxt = S_GAP_X;
      S_GAP_X: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = S_SHIFT_Y;
          w_start     = 1'b1;
        end
      end
      S_SHIFT_Y: if (w_done) w_state_nxt = S_GAP_Y;
      S_GAP_Y:   if (r_cnt == c_gap_last) w_state_nxt = S_LDAC;
      S_LDAC:    if (r_cnt == c_ldac_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ldac_n <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= (w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
      r_ldac_n <= (w_state_nxt != S_LDAC);
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_full <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_act_y     <= '0;
      r_ovr       <= '0;
    end else begin
      if (w_load) r_act_y <= r_pend_y;
      if (i_in_valid) begin
        r_pend_x    <= i_x_in;
        r_pend_y    <= i_y_in;
        r_pend_full <= 1'b1;
        if (r_pend_full && !w_load && (r_ovr != 16'hFFFF)) r_ovr <= r_ovr + 16'd1;
      end else if (w_load) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  spi_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_frame  (w_frame),
    .o_sclk   (o_sclk),
    .o_sdo    (o_sdo),
    .o_sync_n (o_sync_n),
    .o_done   (w_done)
  );

  assign o_ldac_n        = r_ldac_n;
  assign o_busy          = r_busy;
  assign o_overrun_count = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_writer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_dac_spi_writer : directed + random bench with transaction model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dac_spi_writer;

  localparam int CD        = 2;
  localparam int CSH       = 4;
  localparam int LDC       = 2;
  localparam int FRAME_CYC = 48 * CD;
  localparam int TXN       = 96 * CD + 2 * CSH + LDC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        in_valid = 1'b0;
  logic        sclk, sync_n, sdo, ldac_n, busy;
  logic [15:0] ovr;

  always #5 clk = ~clk;

  dac_spi_writer #(
    .CLK_DIV(CD), .CS_HIGH_CYCLES(CSH), .LDAC_CYCLES(LDC),
    .CMD_X(8'h18), .CMD_Y(8'h19), .OFFSET_BINARY(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .i_x_in(x_in), .i_y_in(y_in), .i_in_valid(in_valid),
    .o_sclk(sclk), .o_sync_n(sync_n), .o_sdo(sdo), .o_ldac_n(ldac_n),
    .o_busy(busy), .o_overrun_count(ovr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_t = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_px, m_py;
  int          m_free_at = 0;
  int          m_busy_end = -1;
  int          m_ovr = 0;
  int          m_ldac_exp = 0;
  int          exp_q[$];
  int          exp_end_q[$];

  function automatic int enc(input logic [7:0] cmd, input logic [15:0] s);
    logic [15:0] ob;
    ob = 16'(s + 16'h8000);
    return int'(cmd) * 65536 + int'(ob);
  endfunction

  task automatic model_edge(input bit v, input logic [15:0] x, input logic [15:0] y);
    bit load;
    load = m_pend && (m_t >= m_free_at);
    if (load) begin
      exp_q.push_back(enc(8'h18, m_px)); exp_end_q.push_back(m_t + FRAME_CYC);
      exp_q.push_back(enc(8'h19, m_py)); exp_end_q.push_back(m_t + 2 * FRAME_CYC + CSH);
      m_busy_end = m_t + TXN;
      m_free_at  = m_t + TXN + 1;
      m_ldac_exp++;
    end
    if (v) begin
      if (m_pend && !load && m_ovr < 65535) m_ovr++;
      m_px = x; m_py = y; m_pend = 1'b1;
    end else if (load) begin
      m_pend = 1'b0;
    end
    m_t++;
  endtask

  task automatic model_reset();
    while (exp_end_q.size() > 0 && exp_end_q[exp_end_q.size()-1] >= m_t) begin
      void'(exp_q.pop_back());
      void'(exp_end_q.pop_back());
    end
    if (m_busy_end >= m_t) m_ldac_exp--;
    m_busy_end = -1;
    m_pend = 1'b0; m_ovr = 0; m_free_at = 0;
    m_t++;
  endtask

  // ---------------- passive observer of the SPI pins ----------------
  logic [23:0] cap = '0;
  int          cap_cnt = 0, run = 0, half_min = 1000, half_max = 0;
  int          ld_run = 0, busy_run = 0, sdo_bad = 0;
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_sdo = 1'b0;
  int          got_q[$];
  int          gotbits_q[$];
  int          ldac_w[$];
  int          busy_w[$];

  always @(negedge clk) begin
    if (rst) begin
      cap_cnt = 0; run = 0; ld_run = 0; busy_run = 0;
      prev_sync = 1'b1; prev_sclk = 1'b1; prev_sdo = 1'b0;
    end else begin
      if (!sync_n) begin
        if (prev_sync) run = 1;
        else if (sclk != prev_sclk) begin
          if (run < half_min) half_min = run;
          if (run > half_max) half_max = run;
          run = 1;
        end else run++;
        if (!prev_sync && prev_sclk && !sclk) begin
          cap = {cap[22:0], sdo}; cap_cnt++;
        end
        if (!prev_sync && !sclk && sdo != prev_sdo) sdo_bad++;
      end else if (!prev_sync) begin
        got_q.push_back(int'(cap)); gotbits_q.push_back(cap_cnt); cap_cnt = 0;
      end
      if (!ldac_n) ld_run++;
      else if (ld_run > 0) begin ldac_w.push_back(ld_run); ld_run = 0; end
      if (busy) busy_run++;
      else if (busy_run > 0) begin busy_w.push_back(busy_run); busy_run = 0; end
      prev_sync = sync_n; prev_sclk = sclk; prev_sdo = sdo;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit v, input logic [15:0] x, input logic [15:0] y);
    in_valid = v; x_in = x; y_in = y;
    @(posedge clk);
    model_edge(v, x, y);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick_rst();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 16'h0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || m_pend) && k < 1000) begin
      tick(1'b0, 16'h0, 16'h0); k++;
    end
    chk("idle_timeout", int'(k < 1000), 1);
    idle(3);
  endtask

  task automatic check_frames();
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk("frame", got_q.pop_front(), exp_q.pop_front());
      chk("frame_bits", gotbits_q.pop_front(), 24);
      void'(exp_end_q.pop_front());
    end
    chk("frames_extra", got_q.size(), 0);
    chk("frames_missing", exp_q.size(), 0);
    got_q.delete(); gotbits_q.delete(); exp_q.delete(); exp_end_q.delete();
    chk("ldac_pulses", ldac_w.size(), m_ldac_exp);
    chk("busy_windows", busy_w.size(), m_ldac_exp);
    foreach (ldac_w[i]) chk("ldac_width", ldac_w[i], LDC);
    foreach (busy_w[i]) chk("busy_width", busy_w[i], TXN);
    ldac_w.delete(); busy_w.delete(); m_ldac_exp = 0;
    chk("overrun_model", int'(ovr), m_ovr);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick_rst(); tick_rst();
    chk("rst_sclk", int'(sclk), 1);
    chk("rst_sync_n", int'(sync_n), 1);
    chk("rst_sdo", int'(sdo), 0);
    chk("rst_ldac_n", int'(ldac_n), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(ovr), 0);

    // Single pair, latency and literal frame contents.
    tick(1'b1, 16'h1234, 16'hFFFF);
    chk("lat_sync_before", int'(sync_n), 1);
    chk("lat_busy_before", int'(busy), 0);
    tick(1'b0, 16'h0, 16'h0);
    chk("lat_sync_low", int'(sync_n), 0);
    chk("lat_sclk_high", int'(sclk), 1);
    chk("lat_busy_high", int'(busy), 1);
    chk("lat_sdo_msb", int'(sdo), 0);
    wait_idle();
    chk("single_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("single_x", got_q[0], 24'h189234);
      chk("single_y", got_q[1], 24'h197FFF);
    end
    chk("half_min", half_min, CD);
    chk("half_max", half_max, CD);
    check_frames();

    // Random pairs with random spacing; the model decides what survives.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'($urandom), 16'($urandom));
      idle($urandom_range(100, 300));
    end
    wait_idle();
    check_frames();
    tick_rst();

    // Overrun: B is overwritten by C while A is in flight.
    tick(1'b1, 16'h0001, 16'h0002); idle(9);
    tick(1'b1, 16'h0003, 16'h0004); idle(9);
    tick(1'b1, 16'h0005, 16'h0006);
    wait_idle();
    chk("ovr_count", int'(ovr), 1);
    chk("ovr_frames", got_q.size(), 4);
    if (got_q.size() >= 4) begin
      chk("ovr_first_x", got_q[0], 24'h188001);
      chk("ovr_third_x", got_q[2], 24'h188005);
      chk("ovr_third_y", got_q[3], 24'h198006);
    end
    check_frames();

    // New strobe on the IDLE->SHIFT_X edge: old pair first, no overrun.
    tick(1'b1, 16'h1111, 16'h2222);
    tick(1'b1, 16'h3333, 16'h4444);
    wait_idle();
    chk("simul_ovr", int'(ovr), 1);
    chk("simul_frames", got_q.size(), 4);
    if (got_q.size() >= 4) begin
      chk("simul_old_x", got_q[0], 24'h189111);
      chk("simul_new_x", got_q[2], 24'h18B333);
    end
    check_frames();

    // Reset during bit 10 of the Y frame.
    tick(1'b1, 16'hABCD, 16'h5A5A);
    idle(1 + FRAME_CYC + CSH + 10 * 2 * CD + 1);
    chk("mid_in_y", int'(sync_n), 0);
    tick_rst();
    chk("mid_sync_n", int'(sync_n), 1);
    chk("mid_sclk", int'(sclk), 1);
    chk("mid_ldac_n", int'(ldac_n), 1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_sdo", int'(sdo), 0);
    idle(250);
    chk("mid_no_ldac", ldac_w.size(), 0);
    check_frames();
    tick(1'b1, 16'h0F0F, 16'hF0F0);
    wait_idle();
    chk("mid_clean_cnt", got_q.size(), 2);
    if (got_q.size() >= 1) chk("mid_clean_x", got_q[0], 24'h188F0F);
    check_frames();

    // Saturation: strobe every cycle long enough for >65535 overruns.
    for (int i = 0; i < 66000; i++) tick(1'b1, 16'($urandom), 16'($urandom));
    chk("sat_count", int'(ovr), 16'hFFFF);
    wait_idle();
    chk("sat_hold", int'(ovr), 16'hFFFF);
    check_frames();

    chk("sdo_changes_in_low", sdo_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
